turbosound_bus_seq: RTL and testbench

TURBOSOUND_BUS_SEQ -- requirements
Module: turbosound_bus_seq

---
 rtl/turbosound_bus_seq.sv | 174 +++++++++++++++++
 tb/tb_turbosound_bus_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbosound_bus_seq.sv
// TurboSound PSG bus sequencer: queues CPU port accesses and replays them
// onto the shared AY pair bus as BDIR/BC cycles paced by the PSG clock enable.
module turbosound_bus_seq #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_port,
  input  logic       req_wr,
  input  logic [7:0] req_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] PSG_DI,
  input  logic [7:0] PSG_DO,
  output logic       ay_sel,
  output logic       busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic       port;
    logic       wr;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2,
    GAP    = 2'd3
  } state_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic          bdir_q, bdir_d;
  logic          bc_q, bc_d;
  logic [7:0]    psg_di_q, psg_di_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          ay_sel_q, ay_sel_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          push;
  logic          pop;
  cmd_t          push_cmd;

  // Request payload as stored in the queue
  always_comb begin
    push_cmd      = '0;
    push_cmd.port = req_port;
    push_cmd.wr   = req_wr;
    push_cmd.data = req_data;
  end

  // Next-state, queue bookkeeping and registered bus outputs
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    psg_di_d   = psg_di_q;
    rd_data_d  = rd_data_q;
    ay_sel_d   = ay_sel_q;
    rd_valid_d = 1'b0;
    bdir_d     = 1'b0;
    bc_d       = 1'b0;
    pop        = 1'b0;
    push       = req_valid && req_ready_q;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          cmd_d    = mem_q[rd_ptr_q];
          psg_di_d = mem_q[rd_ptr_q].data;
          state_d  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (CE) begin
          state_d = HOLD;
          // Chip-select escape: register select 0xFE/0xFF picks AY0/AY1
          if (!cmd_q.port && cmd_q.wr && (cmd_q.data[7:1] == 7'h7F)) begin
            ay_sel_d = cmd_q.data[0];
          end
        end
      end
      HOLD: begin
        state_d = GAP;
        if (!cmd_q.wr) begin
          rd_data_d  = PSG_DO;
          rd_valid_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus code follows the state being entered so it lines up with ACTIVE/HOLD
    if ((state_d == ACTIVE) || (state_d == HOLD)) begin
      bdir_d = cmd_d.wr;
      bc_d   = !cmd_d.wr || !cmd_d.port;
    end

    count_d     = count_q + CW'(push) - CW'(pop);
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    req_ready_d = (count_d != CW'(FIFO_DEPTH));
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  // Control and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bdir_q      <= 1'b0;
      bc_q        <= 1'b0;
      psg_di_q    <= 8'h00;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      ay_sel_q    <= 1'b1;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bdir_q      <= bdir_d;
      bc_q        <= bc_d;
      psg_di_q    <= psg_di_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      ay_sel_q    <= ay_sel_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Queue storage; contents are don't-care until the pointers cover them
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign BDIR      = bdir_q;
  assign BC        = bc_q;
  assign PSG_DI    = psg_di_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign ay_sel    = ay_sel_q;

endmodule

// File: tb/tb_turbosound_bus_seq.sv
// Directed bench for turbosound_bus_seq: bus codes, chip select, reads,
// queue back-pressure/ordering and mid-command reset.
module tb_turbosound_bus_seq;

  logic       CLK;
  logic       RESET;
  logic       CE;
  logic       req_valid;
  logic       req_ready;
  logic       req_port;
  logic       req_wr;
  logic [7:0] req_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       BDIR;
  logic       BC;
  logic [7:0] PSG_DI;
  logic [7:0] PSG_DO;
  logic       ay_sel;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [1:0] prev_bus;
  int         n_exec;
  logic [7:0] exec_log [8];

  turbosound_bus_seq #(.FIFO_DEPTH(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .CE        (CE),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_port  (req_port),
    .req_wr    (req_wr),
    .req_data  (req_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .BDIR      (BDIR),
    .BC        (BC),
    .PSG_DI    (PSG_DI),
    .PSG_DO    (PSG_DO),
    .ay_sel    (ay_sel),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Tick and log PSG_DI at every bus command start (00 -> non-00)
  task automatic tick_mon();
    tick();
    if ((prev_bus == 2'b00) && ({BDIR, BC} != 2'b00)) begin
      if (n_exec < 8) exec_log[n_exec] = PSG_DI;
      n_exec++;
    end
    prev_bus = {BDIR, BC};
  endtask

  task automatic send(input logic port, input logic wr, input logic [7:0] data);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_port  = port;
    req_wr    = wr;
    req_data  = data;
    for (int i = 0; i < 50; i++) begin
      ok = req_ready;
      tick();
      if (ok) break;
    end
    req_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && (n < 100)) begin
      tick();
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         k;
    int         acc;
    logic       take;
    logic       seen;

    RESET     = 1'b1;
    CE        = 1'b0;
    req_valid = 1'b0;
    req_port  = 1'b0;
    req_wr    = 1'b0;
    req_data  = 8'h00;
    PSG_DO    = 8'h5A;
    prev_bus  = 2'b00;
    n_exec    = 0;

    // Reset values while RESET is held
    tick();
    tick();
    chk("rst_bus",      {BDIR, BC}, 2'b00);
    chk("rst_psg_di",   PSG_DI,     8'h00);
    chk("rst_rd_valid", rd_valid,   1'b0);
    chk("rst_rd_data",  rd_data,    8'h00);
    chk("rst_ay_sel",   ay_sel,     1'b1);
    chk("rst_busy",     busy,       1'b0);
    chk("rst_ready",    req_ready,  1'b1);
    RESET = 1'b0;
    tick();

    // Select 0x07 then data 0x3E, CE on every 4th clock of ACTIVE
    send(1'b0, 1'b1, 8'h07);
    chk("sel_latency", {BDIR, BC}, 2'b00);
    send(1'b1, 1'b1, 8'h3E);
    chk("sel_code", {BDIR, BC}, 2'b11);
    chk("sel_di",   PSG_DI,     8'h07);
    for (int i = 0; i < 3; i++) begin
      CE = 1'b0; tick();
      chk("sel_wait", {BDIR, BC}, 2'b11);
    end
    CE = 1'b1; tick();
    chk("sel_hold", {BDIR, BC}, 2'b11);
    CE = 1'b0; tick();
    chk("sel_gap", {BDIR, BC}, 2'b00);
    tick();
    chk("sel_idle",   {BDIR, BC}, 2'b00);
    chk("sel_di_hld", PSG_DI,     8'h07);
    tick();
    chk("dat_code", {BDIR, BC}, 2'b10);
    chk("dat_di",   PSG_DI,     8'h3E);
    for (int i = 0; i < 3; i++) begin
      CE = 1'b0; tick();
      chk("dat_wait", {BDIR, BC}, 2'b10);
    end
    CE = 1'b1; tick();
    chk("dat_hold", {BDIR, BC}, 2'b10);
    CE = 1'b0; tick();
    chk("dat_gap", {BDIR, BC}, 2'b00);
    tick();
    chk("dat_idle_busy", busy, 1'b0);

    // Chip select escape codes
    CE = 1'b1;
    send(1'b0, 1'b1, 8'hFE);
    wait_idle();
    chk("ay_fe", ay_sel, 1'b0);
    send(1'b0, 1'b1, 8'hFF);
    chk("ay_ff_acc", ay_sel, 1'b0);
    tick();
    chk("ay_ff_act", ay_sel, 1'b0);
    tick();
    chk("ay_ff_hold", ay_sel, 1'b1);
    wait_idle();
    send(1'b0, 1'b1, 8'h0E);
    wait_idle();
    chk("ay_0e", ay_sel, 1'b1);
    send(1'b0, 1'b1, 8'hFE);
    wait_idle();
    chk("ay_fe2", ay_sel, 1'b0);

    // Data port read returns PSG_DO
    PSG_DO = 8'hA5;
    send(1'b1, 1'b0, 8'h00);
    chk("rd_acc_bus", {BDIR, BC}, 2'b00);
    tick();
    chk("rd_act_bus", {BDIR, BC}, 2'b01);
    chk("rd_act_vld", rd_valid,   1'b0);
    tick();
    chk("rd_hold_bus", {BDIR, BC}, 2'b01);
    chk("rd_hold_vld", rd_valid,   1'b0);
    tick();
    chk("rd_gap_bus",  {BDIR, BC}, 2'b00);
    chk("rd_gap_vld",  rd_valid,   1'b1);
    chk("rd_gap_data", rd_data,    8'hA5);
    PSG_DO = 8'h00;
    tick();
    chk("rd_idle_vld", rd_valid, 1'b0);
    tick();
    chk("rd_data_hold", rd_data, 8'hA5);

    // Six back-to-back data writes with CE stalled: one enters the command
    // register, four fill the queue, then back-pressure
    CE       = 1'b0;
    prev_bus = 2'b00;
    n_exec   = 0;
    k        = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_port  = 1'b1;
      req_wr    = 1'b1;
      d         = 8'h10 + 8'(k);
      req_data  = d;
      take      = req_ready;
      tick_mon();
      if (take) k++;
    end
    chk("bp_accepts", 32'(k),   32'd5);
    chk("bp_ready",   req_ready, 1'b0);
    chk("bp_busy",    busy,      1'b1);
    CE  = 1'b1;
    acc = 0;
    while (((k < 6) || busy) && (acc < 200)) begin
      req_valid = (k < 6);
      d         = 8'h10 + 8'(k);
      req_data  = d;
      take      = req_valid && req_ready;
      tick_mon();
      if (take) k++;
      acc++;
    end
    req_valid = 1'b0;
    chk("bp_drain", 32'(acc < 200), 32'd1);
    chk("bp_nexec", 32'(n_exec),    32'd6);
    for (int i = 0; i < 6; i++) begin
      d = 8'h10 + 8'(i);
      chk($sformatf("bp_order%0d", i), exec_log[i], d);
    end

    // Reset during ACTIVE (read) with three entries queued
    CE     = 1'b0;
    PSG_DO = 8'h77;
    send(1'b1, 1'b0, 8'h00);
    send(1'b1, 1'b1, 8'h01);
    send(1'b1, 1'b1, 8'h02);
    send(1'b1, 1'b1, 8'h03);
    chk("mr_pre_bus",   {BDIR, BC}, 2'b01);
    chk("mr_pre_ready", req_ready,  1'b1);
    #2;
    RESET = 1'b1;
    #1;
    chk("mr_bus",   {BDIR, BC}, 2'b00);
    chk("mr_busy",  busy,       1'b0);
    chk("mr_ready", req_ready,  1'b1);
    chk("mr_vld",   rd_valid,   1'b0);
    chk("mr_ay",    ay_sel,     1'b1);
    tick();
    RESET = 1'b0;
    CE    = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rd_valid || busy || BDIR || BC) seen = 1'b1;
    end
    chk("mr_quiet", seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
